instr_fetch_ctrl: RTL and testbench
===================================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter HALT_WORD, default 32'h0000000C, instruction encoding that ends execution (syscall).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; starts a run from IDLE or HALT.
REQ-005 load_valid  input  1  loader word valid.
REQ-006 load_addr  input  8  loader word index (0..255).
REQ-007 load_data  input  32  loader instruction word.
REQ-008 load_ready  output  1  loader write accepted this cycle when load_valid is high.
REQ-009 imem_addr  output  32  byte address to instruction memory; memory indexes bits [9:2].
REQ-010 imem_we  output  1  memory write enable.
REQ-011 imem_wdata  output  32  memory write data.
REQ-012 imem_rdata  input  32  combinational memory read data for imem_addr.
REQ-013 stall  input  1  downstream hold request.
REQ-014 branch_taken  input  1  redirect request.
REQ-015 branch_target  input  32  redirect byte address.
REQ-016 instr_out  output  32  registered fetched instruction.
REQ-017 pc_out  output  32  registered byte address of instr_out.
REQ-018 instr_valid  output  1  instr_out/pc_out hold a valid instruction.
REQ-019 halted  output  1  high while in HALT.

Function
REQ-020 States are IDLE, RUN, HALT, and the block SHALL hold an internal 32-bit pc register.
REQ-021 In IDLE and HALT: load_ready=1, imem_addr={22'b0,load_addr,2'b00}, imem_wdata=load_data, imem_we=load_valid (combinational, write lands on the same edge).
REQ-022 In RUN: load_ready=0, imem_we=0, imem_addr=pc, and load_valid is ignored.
REQ-023 IDLE/HALT with start=1 -> RUN next edge, pc<=0, instr_valid<=0, halted<=0; a load presented in that same cycle is still written.
REQ-024 RUN, branch_taken=1 (priority over stall and halt detection): pc<=branch_target with bits [1:0] forced to 0, instr_valid<=0 (flush), instr_out/pc_out hold.
REQ-025 RUN, stall=1, branch_taken=0: pc, instr_out, pc_out, instr_valid all hold.
REQ-026 RUN, neither: instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4 modulo 2^32; fetch latency is one cycle.
REQ-027 Under REQ-026, when imem_rdata==HALT_WORD, the halt word is still captured with instr_valid<=1, pc holds, and state<=HALT.
REQ-028 Entering HALT: instr_valid<=0 on the first edge in HALT; halted=1 throughout HALT.
REQ-029 pc past 32'h3FC continues to 32'h400, and memory indexing wraps to word 0; no error is flagged.
REQ-030 start while in RUN SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, pc=0, instr_out=0, pc_out=0, instr_valid=0, halted=0; imem_we then follows REQ-021.
REQ-032 Reset asserted mid-run or mid-load SHALL abort with no further write; memory contents are not cleared.

Verification
REQ-033 Load words 0..2 = 0x20080005, 0x20090003, HALT_WORD, then pulse start -> instr_valid on cycles 2,3,4 after start with pc_out 0,4,8, then halted=1 and instr_valid=0.
REQ-034 RUN, stall high for 3 cycles at pc=8 -> instr_out/pc_out/pc unchanged for 3 cycles, then resume at pc_out=8.
REQ-035 branch_taken with target 0x00000043 and stall=1 in the same cycle -> instr_valid=0 next cycle, next fetched pc_out=0x40.
REQ-036 load_valid pulsed during RUN -> load_ready=0, imem_we=0, memory unchanged (verify by readback after halt).
REQ-037 No halt word in memory, run 256+ fetches -> pc reaches 0x400, instr_out equals word 0, and pc_out=0x400.
REQ-038 rst_n dropped between edges mid-RUN -> all outputs at reset values before the next edge, state IDLE, load_ready=1.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: preloads instruction memory while idle or halted,
// then fetches sequentially from pc with stall/branch handling until a halt word is fetched.
module instr_fetch_ctrl #(
    parameter logic [31:0] HALT_WORD = 32'h0000000C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        load_valid,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;

    assign dbg_state = state;

    // Loader handshake: a word is written on any edge where load_valid is high
    // and load_ready is high; load_ready is high exactly when not running.
    always_comb begin
        load_ready = 1'b1;
        imem_we    = load_valid;
        imem_addr  = {22'b0, load_addr, 2'b00};
        imem_wdata = load_data;
        if (state == S_RUN) begin
            load_ready = 1'b0;
            imem_we    = 1'b0;
            imem_addr  = pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= 32'd0;
            instr_out   <= 32'd0;
            pc_out      <= 32'd0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    // The halt word stays visible as valid for exactly one cycle.
                    if (state == S_HALT) instr_valid <= 1'b0;
                    if (start) begin
                        state       <= S_RUN;
                        pc          <= 32'd0;
                        instr_valid <= 1'b0;
                        halted      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (branch_taken) begin
                        pc          <= {branch_target[31:2], 2'b00};
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        instr_out   <= imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        if (imem_rdata == HALT_WORD) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural fetch model with its own memory image.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] HALT_WORD = 32'h0000000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_addr = 8'd0;
    logic [31:0] load_data = 32'd0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        load_ready;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        halted;
    logic [1:0]  dbg_state;

    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    // Behavioural model: running/halted flags, fetch pointer, last delivered fetch.
    logic [31:0] ref_mem [256];
    logic        m_run, m_halt, m_valid;
    logic [31:0] m_pc, m_pcout, m_instr;

    // ---------------- clock / memory ----------------
    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[9:2]];
    always @(posedge clk) if (imem_we) mem[imem_addr[9:2]] <= imem_wdata;

    instr_fetch_ctrl #(.HALT_WORD(HALT_WORD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .imem_addr(imem_addr), .imem_we(imem_we),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .halted(halted), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_halt = 1'b0; m_valid = 1'b0;
        m_pc = 32'd0; m_pcout = 32'd0; m_instr = 32'd0;
    endtask

    // One clock edge of the fetch rules applied to the model.
    task automatic model_step();
        logic [31:0] w;
        if (!m_run) begin
            if (load_valid) ref_mem[load_addr] = load_data;
            if (start) begin
                m_run = 1'b1; m_halt = 1'b0; m_pc = 32'd0; m_valid = 1'b0;
            end else if (m_halt) begin
                m_valid = 1'b0;
            end
        end else if (branch_taken) begin
            m_pc    = branch_target & 32'hFFFF_FFFC;
            m_valid = 1'b0;
        end else if (!stall) begin
            w       = ref_mem[m_pc[9:2]];
            m_instr = w;
            m_pcout = m_pc;
            m_valid = 1'b1;
            if (w == HALT_WORD) begin
                m_run  = 1'b0;
                m_halt = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic st, input logic lv, input logic [7:0] la,
                         input logic [31:0] ld, input logic stl, input logic br,
                         input logic [31:0] bt);
        start = st; load_valid = lv; load_addr = la; load_data = ld;
        stall = stl; branch_taken = br; branch_target = bt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    // Inputs are set by the caller just after a rising edge; tick checks the
    // combinational side mid-cycle, then the registered side after the edge.
    task automatic tick();
        @(negedge clk);
        check("load_ready", {31'b0, load_ready}, {31'b0, !m_run});
        check("imem_we", {31'b0, imem_we}, {31'b0, !m_run && load_valid});
        check("imem_addr", imem_addr, m_run ? m_pc : {22'b0, load_addr, 2'b00});
        if (!m_run) check("imem_wdata", imem_wdata, load_data);
        @(posedge clk);
        model_step();
        #1;
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check("halted", {31'b0, halted}, {31'b0, m_halt});
        check("pc_out", pc_out, m_pcout);
        check("instr_out", instr_out, m_instr);
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d, 1'b0, 1'b0, 32'd0);
        tick();
        idle();
    endtask

    task automatic start_run();
        drive(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        idle();
    endtask

    task automatic run_to_halt(input int budget);
        int n = 0;
        while (m_run && n < budget) begin
            tick();
            n++;
        end
        check("halt_reached", {31'b0, m_halt}, 32'd1);
    endtask

    task automatic run_to_pc(input logic [31:0] target, input int budget);
        int n = 0;
        while (m_run && m_pc != target && n < budget) begin
            tick();
            n++;
        end
        check("pc_reached", m_pc, target);
    endtask

    // Reset dropped between edges; outputs must respond before the next edge.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        idle();
        #1;
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_load_ready", {31'b0, load_ready}, 32'd1);
        check("rst_state_idle", {30'b0, dbg_state}, 32'd0);
        check("rst_imem_we", {31'b0, imem_we}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic readback(input logic [7:0] a);
        logic [31:0] e;
        load_valid = 1'b0;
        load_addr  = a;
        #1;
        e = exp_q.pop_front();
        check("readback", imem_rdata, e);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if (w == HALT_WORD) w = w ^ 32'h1;
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #12;
        check("reset_valid", {31'b0, instr_valid}, 32'd0);
        check("reset_halted", {31'b0, halted}, 32'd0);
        check("reset_pc_out", pc_out, 32'd0);
        check("reset_load_ready", {31'b0, load_ready}, 32'd1);
        check("reset_state_idle", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 256; i++) load_word(8'(i), rand_word());

        // Three-word program ending in the halt word.
        load_word(8'd0, 32'h20080005);
        load_word(8'd1, 32'h20090003);
        load_word(8'd2, HALT_WORD);
        start_run();
        run_to_halt(20);
        check("halt_pc_out", pc_out, 32'd8);
        check("halt_instr", instr_out, HALT_WORD);
        check("halt_valid_first", {31'b0, instr_valid}, 32'd1);
        tick();
        check("halt_valid_drop", {31'b0, instr_valid}, 32'd0);
        check("halt_flag", {31'b0, halted}, 32'd1);

        // Loader pulse while running must be ignored.
        start_run();
        drive(1'b0, 1'b1, 8'd1, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        tick();
        idle();
        run_to_halt(20);
        exp_q.push_back(32'h20090003);
        readback(8'd1);

        // Stall for three cycles with pc at 8.
        load_word(8'd2, 32'h20080005);
        load_word(8'd4, HALT_WORD);
        start_run();
        run_to_pc(32'd8, 20);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        repeat (3) tick();
        check("stall_pc_out", pc_out, 32'd4);
        idle();
        tick();
        check("resume_pc_out", pc_out, 32'd8);
        run_to_halt(20);

        // Branch with stall in the same cycle; target low bits dropped.
        start_run();
        run_to_pc(32'd4, 20);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b1, 32'h00000043);
        tick();
        check("branch_flush", {31'b0, instr_valid}, 32'd0);
        idle();
        tick();
        check("branch_pc_out", pc_out, 32'h40);
        run_to_halt(400);

        // No halt word anywhere: run past the end of memory.
        load_word(8'd4, 32'h11111111);
        start_run();
        repeat (257) tick();
        check("wrap_pc_out", pc_out, 32'h400);
        check("wrap_instr", instr_out, 32'h20080005);
        check("wrap_valid", {31'b0, instr_valid}, 32'd1);
        async_reset();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            drive(($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) == 0),
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 5) == 0) ? HALT_WORD : rand_word(),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  $urandom);
            tick();
            if ($urandom_range(0, 399) == 0) async_reset();
        end
        idle();
        async_reset();

        for (int i = 0; i < 16; i++) begin
            logic [7:0] a = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_mem[a]);
            readback(a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
